modmul_arbiter: RTL

MODMUL_ARBITER -- requirements
Module: modmul_arbiter

---
 rtl/modmul_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/modmul_arbiter.sv
// Two-requester round-robin front end for a modular multiplier core: grants a job,
// resets and launches the core, waits for done or timeout, then holds the response.
module modmul_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_x0,
  input  logic [255:0] req_y0,
  input  logic [255:0] req_x1,
  input  logic [255:0] req_y1,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [255:0] resp_q,
  output logic         resp_err,
  output logic         busy,
  output logic         mm_rst,
  output logic         mm_start,
  output logic [255:0] mm_x,
  output logic [255:0] mm_y,
  input  logic [255:0] mm_q,
  input  logic         mm_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic           prio_q, prio_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [255:0]   x_q, x_d, y_q, y_d;
  logic [255:0]   rq_q, rq_d;
  logic           rerr_q, rerr_d;
  logic           rid_q, rid_d;
  logic           gid;
  logic [1:0]     gnt;

  // With both requesters pending, prio_q names the one that was not served last.
  always_comb begin
    gid = (&req_valid) ? prio_q : req_valid[1];
    gnt = gid ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    rq_d      = rq_q;
    rerr_d    = rerr_q;
    rid_d     = rid_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = rst ? 2'b00 : gnt;
          x_d       = gid ? req_x1 : req_x0;
          y_d       = gid ? req_y1 : req_y0;
          rid_d     = gid;
          prio_d    = ~gid;
          state_d   = CLEAR;
        end
      end
      CLEAR:  state_d = LAUNCH;
      LAUNCH: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // Completion takes precedence over a timeout landing on the same cycle.
        if (mm_done) begin
          rq_d    = mm_q;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rq_d    = '0;
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rq_q    <= '0;
      rerr_q  <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rq_q    <= rq_d;
      rerr_q  <= rerr_d;
      rid_q   <= rid_d;
    end
  end

  assign mm_rst     = rst | (state_q == CLEAR);
  assign mm_start   = (state_q == LAUNCH);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign mm_x       = x_q;
  assign mm_y       = y_q;
  assign resp_q     = rq_q;
  assign resp_err   = rerr_q;
  assign resp_id    = rid_q;

endmodule
